// File: rtl/multi_trigger_pkg.sv
// multi_trigger_pkg: shared types for the multi-channel trigger generator.
//   state_t : FSM states, encoding is also the O_state readback value.
//   mode_t  : qualification modes driven on I_mode.
package multi_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_ANY  = 2'd0,
    MODE_ALL  = 2'd1,
    MODE_SEQ  = 2'd2,
    MODE_RSVD = 2'd3   // behaves as MODE_ANY
  } mode_t;

endpackage

// File: rtl/multi_trigger_seq_tracker.sv
// trigger_seq_tracker: ordered-match tracker for SEQ mode.
//   fe_clk, reset_i : clock, synchronous active-high reset
//   en              : enabled channel mask
//   match           : per-channel match strobes
//   clear           : force the index back to the first enabled channel
//   qualify         : combinational, high in the cycle the last enabled
//                     channel matches in order
// idx holds a channel number; the expected channel is the lowest enabled
// channel at or above idx.
module trigger_seq_tracker #(
  parameter int pCHANNELS = 4
) (
  input  logic                 fe_clk,
  input  logic                 reset_i,
  input  logic [pCHANNELS-1:0] en,
  input  logic [pCHANNELS-1:0] match,
  input  logic                 clear,
  output logic                 qualify
);

  localparam int IDX_W = $clog2(pCHANNELS + 1);

  logic [IDX_W-1:0]     idx, idx_next;
  logic [IDX_W-1:0]     exp_pos, first_pos;
  logic [pCHANNELS-1:0] exp_oh, first_oh;
  logic                 found, first_found, any_later, hit, other;

  always_comb begin
    exp_oh      = '0;
    first_oh    = '0;
    exp_pos     = '0;
    first_pos   = '0;
    found       = 1'b0;
    first_found = 1'b0;
    any_later   = 1'b0;
    for (int i = 0; i < pCHANNELS; i++) begin
      if (en[i] && !first_found) begin
        first_found = 1'b1;
        first_oh[i] = 1'b1;
        first_pos   = IDX_W'(i);
      end
      // Checked before 'found' is set on this index: only strictly later
      // enabled channels count.
      if (en[i] && found) any_later = 1'b1;
      if (en[i] && !found && (IDX_W'(i) >= idx)) begin
        found     = 1'b1;
        exp_oh[i] = 1'b1;
        exp_pos   = IDX_W'(i);
      end
    end

    hit   = |(match & exp_oh);
    other = |(match & en & ~exp_oh);

    qualify  = 1'b0;
    idx_next = idx;
    if (clear || (en == '0)) begin
      idx_next = '0;
    end else if (other) begin
      // Out-of-order match restarts the sequence; the same cycle may still
      // satisfy the first enabled channel.
      idx_next = (|(match & first_oh)) ? (first_pos + IDX_W'(1)) : '0;
    end else if (hit) begin
      if (!any_later) begin
        qualify  = 1'b1;
        idx_next = '0;
      end else begin
        idx_next = exp_pos + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) idx <= '0;
    else         idx <= idx_next;
  end

endmodule

// File: rtl/multi_trigger.sv
// multi_trigger: multi-channel trigger qualifier and trigger-train generator.
//   Inputs : fe_clk, reset_i, I_arm (rising edge starts a run),
//            I_trigger_enable, I_mode, I_channel_enable, I_match,
//            I_num_triggers (0 = unlimited), I_holdoff, I_capture_off,
//            I_capturing
//   Outputs: O_trigger, O_trigger_channel, O_triggers_generated,
//            O_triggering, O_state, O_capture_enable, O_capture_enable_pulse
// Handshake: none; I_match is a level sampled every fe_clk cycle and
// O_trigger is a single-cycle strobe with no back-pressure.
module multi_trigger
  import multi_trigger_pkg::*;
#(
  parameter int  pCHANNELS          = 4,
  parameter int  pNUM_TRIGGER_WIDTH = 16,
  parameter int  pHOLDOFF_WIDTH     = 16,
  localparam int CH_W = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
  input  logic                          fe_clk,
  input  logic                          reset_i,
  input  logic                          I_arm,
  input  logic                          I_trigger_enable,
  input  logic [1:0]                    I_mode,
  input  logic [pCHANNELS-1:0]          I_channel_enable,
  input  logic [pCHANNELS-1:0]          I_match,
  input  logic [pNUM_TRIGGER_WIDTH-1:0] I_num_triggers,
  input  logic [pHOLDOFF_WIDTH-1:0]     I_holdoff,
  input  logic                          I_capture_off,
  input  logic                          I_capturing,
  output logic                          O_trigger,
  output logic [CH_W-1:0]               O_trigger_channel,
  output logic [pNUM_TRIGGER_WIDTH-1:0] O_triggers_generated,
  output logic                          O_triggering,
  output logic [1:0]                    O_state,
  output logic                          O_capture_enable,
  output logic                          O_capture_enable_pulse
);

  state_t                          state, state_next;
  logic [pNUM_TRIGGER_WIDTH-1:0]   count, count_next, count_inc;
  logic [pHOLDOFF_WIDTH-1:0]       hold, hold_next;
  logic                            arm_r, ten_r, capturing_r;
  logic                            cap_reg, cap_reg_d, pulse_q, trig_q;
  logic [CH_W-1:0]                 chan_q, low_ch;
  logic [pCHANNELS-1:0]            masked;
  logic                            arm_edge, qual, seq_q, qualified_now;
  logic                            seq_clear, capture_done;
  mode_t                           mode;

  assign mode     = mode_t'(I_mode);
  assign arm_edge = I_arm & ~arm_r;
  assign masked   = I_match & I_channel_enable;

  assign seq_clear = (state != ST_ARMED) | arm_edge | (mode != MODE_SEQ);

  trigger_seq_tracker #(.pCHANNELS(pCHANNELS)) u_seq (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .en      (I_channel_enable),
    .match   (I_match),
    .clear   (seq_clear),
    .qualify (seq_q)
  );

  always_comb begin
    qual = |masked;
    case (mode)
      MODE_ALL: qual = (I_channel_enable != '0) && (masked == I_channel_enable);
      MODE_SEQ: qual = seq_q;
      default:  qual = |masked;
    endcase
  end

  // An arm edge in the same cycle drops the match.
  assign qualified_now = ~reset_i & ~arm_edge & (state == ST_ARMED) & ten_r & qual;

  always_comb begin
    low_ch = '0;
    for (int i = pCHANNELS - 1; i >= 0; i--) begin
      if (masked[i]) low_ch = CH_W'(i);
    end
  end

  assign count_inc = (&count) ? count : (count + 1'b1);

  always_comb begin
    state_next = state;
    count_next = count;
    hold_next  = hold;
    if (arm_edge) begin
      state_next = ST_ARMED;
      count_next = '0;
      hold_next  = '0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (qualified_now) begin
            count_next = count_inc;
            if ((I_num_triggers != '0) && (count_inc == I_num_triggers)) begin
              state_next = ST_DONE;
            end else if (I_holdoff != '0) begin
              state_next = ST_HOLDOFF;
              hold_next  = I_holdoff;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold <= 1) begin
            state_next = ST_ARMED;
            hold_next  = '0;
          end else begin
            hold_next = hold - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign capture_done = I_capture_off ? (state == ST_DONE) : (capturing_r & ~I_capturing);

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      count       <= '0;
      hold        <= '0;
      arm_r       <= 1'b0;
      ten_r       <= 1'b0;
      capturing_r <= 1'b0;
      trig_q      <= 1'b0;
      chan_q      <= '0;
      cap_reg     <= 1'b0;
      cap_reg_d   <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      hold        <= hold_next;
      arm_r       <= I_arm;
      ten_r       <= I_trigger_enable;
      capturing_r <= I_capturing;
      trig_q      <= qualified_now;
      if (qualified_now) chan_q <= low_ch;
      // Clear has priority over set.
      if (capture_done)       cap_reg <= 1'b0;
      else if (qualified_now) cap_reg <= 1'b1;
      cap_reg_d   <= cap_reg;
      pulse_q     <= cap_reg & ~cap_reg_d;
    end
  end

  assign O_trigger              = trig_q;
  assign O_trigger_channel      = chan_q;
  assign O_triggers_generated   = count;
  assign O_triggering           = (state == ST_ARMED) || (state == ST_HOLDOFF);
  assign O_state                = state;
  assign O_capture_enable       = (qualified_now | cap_reg) & ~I_capture_off;
  assign O_capture_enable_pulse = pulse_q;

endmodule

// File: doc/multi_trigger.md
# multi_trigger

Parametrised multi-channel successor to the single-match trigger generator: qualifies up to pCHANNELS pattern-match inputs in ANY, ALL or SEQUENCE mode, then emits a bounded train of one-cycle triggers with programmable holdoff. It sits between the pattern-match blocks and the capture block in the fe_clk domain. It drives capture enable/pulse exactly as the existing trigger path does, so the capture block is unchanged.

## Interface
Parameters:
- pCHANNELS, 4: number of match inputs (1..16).
- pNUM_TRIGGER_WIDTH, 16: width of trigger count/limit.
- pHOLDOFF_WIDTH, 16: width of holdoff counter.

Ports (one clock, `fe_clk`; reset `reset_i` is synchronous, active-high):
- fe_clk  in  1  front-end clock; all logic in this domain.
- reset_i  in  1  synchronous active-high reset.
- I_arm  in  1  rising edge (re)starts a trigger run.
- I_trigger_enable  in  1  global trigger gate; registered once before use.
- I_mode  in  2  0=ANY, 1=ALL, 2=SEQ, 3=reserved (treated as ANY).
- I_channel_enable  in  pCHANNELS  per-channel qualifier mask.
- I_match  in  pCHANNELS  per-channel match strobes.
- I_num_triggers  in  pNUM_TRIGGER_WIDTH  trigger limit; 0 = unlimited.
- I_holdoff  in  pHOLDOFF_WIDTH  dead cycles after each trigger.
- I_capture_off  in  1  suppress capture enable; capture done = run done.
- I_capturing  in  1  capture block busy.
- O_trigger  out  1  one-cycle trigger pulse.
- O_trigger_channel  out  clog2(pCHANNELS) (min 1)  lowest enabled channel that qualified the last trigger.
- O_triggers_generated  out  pNUM_TRIGGER_WIDTH  triggers since arm; saturates at all-ones.
- O_triggering  out  1  high in ARMED/HOLDOFF.
- O_state  out  2  FSM state, for status readback.
- O_capture_enable  out  1  capture window.
- O_capture_enable_pulse  out  1  one-cycle pulse on capture enable rise.

## Operation
- States: IDLE(0), ARMED(1), HOLDOFF(2), DONE(3). Reset: IDLE. All outputs 0 on reset.
- IDLE -> ARMED on I_arm rising edge (arm_r registered). Edge in any state: clear count, sequence index, holdoff counter, go ARMED.
- Qualification in ARMED, with en = I_channel_enable:
  - ANY: |(I_match & en).
  - ALL: (I_match & en) == en, and en != 0.
  - SEQ: enabled channels must match in ascending index order, one per cycle or later. Match on the expected channel advances the index. Match on an enabled out-of-order channel resets the index to 0, and that cycle's match is re-evaluated as channel 0 candidate. Qualifies when the last enabled channel matches in order; the index then resets.
  - en == 0 never qualifies.
- Qualified & trigger_enable_r: O_trigger=1 next cycle; count += 1 (saturating); then:
  - if I_num_triggers != 0 and new count == I_num_triggers -> DONE;
  - else if I_holdoff != 0 -> HOLDOFF, load counter = I_holdoff;
  - else stay ARMED.
- HOLDOFF: matches ignored, SEQ index held at 0; decrement; at 1 -> ARMED.
- DONE: no triggers until next arm edge.
- Capture: capture_done = I_capture_off ? (state==DONE) : falling edge of I_capturing.
  - capture_enable_reg set on qualified trigger, cleared on capture_done; clear wins if both occur.
  - O_capture_enable = (qualified_now | capture_enable_reg) & ~I_capture_off.
  - O_capture_enable_pulse = registered rise of capture_enable_reg.

## Timing
- Match -> O_trigger: 1 cycle (trigger_enable_r adds 1 cycle of enable latency).
- Match -> O_capture_enable: 0 cycles (combinational start term).
- O_capture_enable_pulse: 2 cycles after qualifying match.
- Minimum trigger spacing: 1 cycle with holdoff 0; otherwise I_holdoff+1.
- Arm edge and qualified match in the same cycle: the arm wins; the match is dropped and count=0.
- reset_i mid-run: IDLE next cycle; the capture register clears.

## Structure
- Package multi_trigger_pkg: state and mode enums, MODE_* and ST_* constants.
- Sub-module trigger_seq_tracker holds the SEQ index register and emits a qualify pulse. Parameter pCHANNELS; inputs en, match, clear.

## Test plan
- ANY, en=4'b0101, num=3, holdoff=0: matches on ch2 at cycles 10, 11, 12, 13 -> triggers at 11, 12, 13; DONE; count=3; ch=2.
- ALL, en=4'b0011: match=0001 then 0011 -> single trigger, only after 0011.
- SEQ, en=4'b1011: matches ch0, ch1, ch3 -> trigger. Sequence ch0, ch3 -> no trigger, index resets.
- Holdoff=5, unlimited: continuous match -> triggers every 6 cycles; O_triggering stays 1.
- I_capture_off=1, num=2 -> O_capture_enable stays 0; capture_done occurs on DONE. With I_capture_off=0, an I_capturing fall clears enable.
- Re-arm edge in HOLDOFF, and reset_i asserted mid-ARMED -> count=0, state ARMED/IDLE respectively, no spurious O_trigger.
